// File: rtl/sd_debug_pkg.sv
// Shared types and helpers for the SD debug hex monitor.
// Holds the formatter state enum, ASCII constants and hex_ascii().
package sd_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_SEP,
        ST_CR,
        ST_LF
    } fmt_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] n8;
        n8 = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + n8;
        end
        return 8'h37 + n8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, CLKS_PER_BIT = FREQ/BAUD clocks per bit.
// Ports: clk, resetn (async low), data/start in, ready/txd out.
module uart_tx_byte #(
    parameter int FREQ = 27_000_000,
    parameter int BAUD = 115_200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       txd
);

    localparam int CLKS_PER_BIT = FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    // bit_q: 0 = start, 1..8 = data, 9 = stop
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                cnt_d    = '0;
                bit_d    = 4'd0;
                shift_d  = data;
                txd_d    = 1'b0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
                txd_d    = 1'b1;
            end else begin
                bit_d = bit_q + 4'd1;
                // ones shift in behind the data, so the
                // ninth output is the stop bit
                txd_d   = shift_q[0];
                shift_d = {1'b1, shift_q[7:1]};
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 8'hFF;
            txd_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    assign ready = ~active_q;
    assign txd   = txd_q;

endmodule

// File: rtl/sd_hexdump_uart.sv
// SD-read debug monitor: buffers bytes in a FIFO and prints them as
// "XX " hex on a UART, CR LF every BYTES_PER_LINE bytes.
// Ports: clk, resetn (async low), din/din_valid in;
//        uart_txd, sticky overflow, fifo_level, busy out.
module sd_hexdump_uart
    import sd_debug_pkg::*;
#(
    parameter int FREQ           = 27_000_000,
    parameter int BAUD           = 115_200,
    parameter int FIFO_DEPTH     = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  din,
    input  logic                        din_valid,
    output logic                        uart_txd,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int NW  = $clog2(BYTES_PER_LINE + 1);
    localparam logic [LW-1:0] FULL_CNT = LW'(FIFO_DEPTH);
    localparam logic [NW-1:0] LAST_COL = NW'(BYTES_PER_LINE - 1);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    fmt_state_e    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [NW-1:0] line_q, line_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          tx_start;
    logic          tx_ready;
    logic [7:0]    tx_data;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    // a pop in the same cycle frees the slot for the write
    assign fifo_push  = din_valid & (~fifo_full | fifo_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + LW'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_d = count_q - LW'(1);
        end
        if (din_valid && !fifo_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Each send state fires tx_start once the transmitter is ready and
    // moves on; the following send waits for ready to return.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        line_d   = line_q;
        fifo_pop = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = mem_q[rd_ptr_q];
                    state_d  = ST_HI;
                end
            end
            ST_HI: begin
                tx_data = hex_ascii(hold_q[7:4]);
                if (tx_ready) begin
                    tx_start = 1'b1;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                tx_data = hex_ascii(hold_q[3:0]);
                if (tx_ready) begin
                    tx_start = 1'b1;
                    if (line_q == LAST_COL) begin
                        state_d = ST_CR;
                    end else begin
                        state_d = ST_SEP;
                    end
                end
            end
            ST_SEP: begin
                tx_data = ASCII_SPACE;
                if (tx_ready) begin
                    tx_start = 1'b1;
                    line_d   = line_q + NW'(1);
                    state_d  = ST_IDLE;
                end
            end
            ST_CR: begin
                tx_data = ASCII_CR;
                if (tx_ready) begin
                    tx_start = 1'b1;
                    state_d  = ST_LF;
                end
            end
            ST_LF: begin
                tx_data = ASCII_LF;
                if (tx_ready) begin
                    tx_start = 1'b1;
                    line_d   = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'h00;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            line_q  <= line_d;
        end
    end

    uart_tx_byte #(
        .FREQ (FREQ),
        .BAUD (BAUD)
    ) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .data   (tx_data),
        .start  (tx_start),
        .ready  (tx_ready),
        .txd    (uart_txd)
    );

    assign overflow   = overflow_q;
    assign fifo_level = count_q;
    assign busy       = ~fifo_empty | (state_q != ST_IDLE) | ~tx_ready;

endmodule

// File: tb/tb_sd_hexdump_uart.sv
// Self-checking bench for sd_hexdump_uart: UART decoder plus a
// reference model of the hex formatting, one task per scenario.
module tb_sd_hexdump_uart;

    localparam int CPB   = 8;
    localparam int BPL   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic [7:0] din;
    logic       din_valid;
    logic       uart_txd;
    logic       overflow;
    logic [2:0] fifo_level;
    logic       busy;

    logic       resetn2;
    logic [7:0] din2;
    logic       din_valid2;
    logic       txd2;
    logic       ovf2;
    logic [4:0] lvl2;
    logic       busy2;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_err = 0;
    int line_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    sd_hexdump_uart #(
        .FREQ(8), .BAUD(1),
        .FIFO_DEPTH(DEPTH), .BYTES_PER_LINE(BPL)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .uart_txd   (uart_txd),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    sd_hexdump_uart dut2 (
        .clk        (clk),
        .resetn     (resetn2),
        .din        (din2),
        .din_valid  (din_valid2),
        .uart_txd   (txd2),
        .overflow   (ovf2),
        .fifo_level (lvl2),
        .busy       (busy2)
    );

    // UART receiver for the small instance
    logic [7:0] rxb;
    always begin
        @(negedge uart_txd);
        repeat (CPB / 2) @(posedge clk);
        if (uart_txd == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                rxb[i] = uart_txd;
            end
            repeat (CPB) @(posedge clk);
            if (uart_txd === 1'b1) rx_q.push_back(rxb);
            else frame_err++;
        end
    end

    // edge timestamps for the full-rate instance
    int cyc = 0;
    logic prev2 = 1'b1;
    logic prevb2 = 1'b0;
    int fall_q[$];
    int rise_q[$];
    int bfall = -1;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev2 <= txd2;
        prevb2 <= busy2;
        if (prev2 === 1'b1 && txd2 === 1'b0) fall_q.push_back(cyc);
        if (prev2 === 1'b0 && txd2 === 1'b1) rise_q.push_back(cyc);
        if (prevb2 === 1'b1 && busy2 === 1'b0) bfall <= cyc;
    end

    // reference: every accepted byte becomes two hex digits and
    // then a space, or CR LF when it closes a line
    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(55 + n);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_q.push_back(hexc(int'(b) / 16));
        exp_q.push_back(hexc(int'(b) % 16));
        if (line_cnt == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            line_cnt = 0;
        end else begin
            exp_q.push_back(8'h20);
            line_cnt++;
        end
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din = 8'h00;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rx_q.delete();
        exp_q.delete();
        line_cnt = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 5000) $display("FAIL %s_idle: busy stuck, want 0", nm);
        else n_pass++;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic check_stream(input string nm);
        wait_idle(nm);
        n_checks++;
        if (rx_q.size() !== exp_q.size())
            $display("FAIL %s_len: got %0d chars want %0d",
                     nm, rx_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size())
                $display("FAIL %s_chr%0d: missing want %h",
                         nm, i, exp_q[i]);
            else if (rx_q[i] !== exp_q[i])
                $display("FAIL %s_chr%0d: got %h want %h",
                         nm, i, rx_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (frame_err !== 0)
            $display("FAIL %s_frame: got %0d errors want 0",
                     nm, frame_err);
        else n_pass++;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        din_valid = 1'b0;
        din = 8'h00;
        #12;
        n_checks++;
        if (uart_txd !== 1'b1)
            $display("FAIL rst_txd: got %b want 1", uart_txd);
        else n_pass++;
        do_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL rst_ovf: got %b want 0", overflow);
        else n_pass++;
        n_checks++;
        if (fifo_level !== 3'd0)
            $display("FAIL rst_lvl: got %0d want 0", fifo_level);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_single();
        int k;
        do_reset();
        @(negedge clk);
        din = 8'hA5;
        din_valid = 1'b1;
        model_byte(8'hA5);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (uart_txd !== 1'b1)
            $display("FAIL lat_early: got %b want 1", uart_txd);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (uart_txd !== 1'b0)
            $display("FAIL lat_start: got %b want 0", uart_txd);
        else n_pass++;
        k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k < 3 * 10 * CPB || k > 3 * 10 * CPB + 6)
            $display("FAIL busy_drop: got %0d clk want %0d..%0d",
                     k, 3 * 10 * CPB, 3 * 10 * CPB + 6);
        else n_pass++;
        check_stream("single");
    endtask

    task automatic test_line();
        logic [7:0] v [4];
        v[0] = 8'h00; v[1] = 8'h01; v[2] = 8'h02; v[3] = 8'h0F;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = v[i];
            din_valid = 1'b1;
            model_byte(v[i]);
            @(negedge clk);
            din_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check_stream("line");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (overflow !== (i - 1 >= 5))
                    $display("FAIL ovf_at%0d: got %b want %b",
                             i, overflow, (i - 1 >= 5));
                else n_pass++;
            end
            din = 8'h10 + 8'(i);
            din_valid = 1'b1;
            if (i < 5) model_byte(8'h10 + 8'(i));
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4)
            $display("FAIL ovf_lvl: got %0d want 4", fifo_level);
        else n_pass++;
        check_stream("ovf");
        n_checks++;
        if (overflow !== 1'b1)
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        else n_pass++;
    endtask

    task automatic test_pop_collide();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din = 8'h20 + 8'(i);
            din_valid = 1'b1;
            model_byte(8'h20 + 8'(i));
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4)
            $display("FAIL col_full: got %0d want 4", fifo_level);
        else n_pass++;
        n = 0;
        while (dut.fifo_pop !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 1000) $display("FAIL col_wait: no pop, want pop");
        else n_pass++;
        din = 8'h99;
        din_valid = 1'b1;
        model_byte(8'h99);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4)
            $display("FAIL col_lvl: got %0d want 4", fifo_level);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL col_ovf: got %b want 0", overflow);
        else n_pass++;
        check_stream("collide");
    endtask

    task automatic test_reset_midframe();
        int n;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din = 8'h30 + 8'(i);
            din_valid = 1'b1;
        end
        @(negedge clk);
        din_valid = 1'b0;
        n = 0;
        while (uart_txd !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4 * CPB + 2) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_level !== 3'd2)
            $display("FAIL mid_pre_lvl: got %0d want 2", fifo_level);
        else n_pass++;
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (uart_txd !== 1'b1)
            $display("FAIL mid_txd: got %b want 1", uart_txd);
        else n_pass++;
        n_checks++;
        if (fifo_level !== 3'd0)
            $display("FAIL mid_lvl: got %0d want 0", fifo_level);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL mid_busy: got %b want 0", busy);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        rx_q.delete();
        exp_q.delete();
        frame_err = 0;
        line_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h7E : 8'($urandom_range(0, 255));
            @(negedge clk);
            din = b;
            din_valid = 1'b1;
            model_byte(b);
            @(negedge clk);
            din_valid = 1'b0;
        end
        check_stream("midrst");
    endtask

    task automatic test_random();
        int k;
        logic [7:0] b;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom_range(0, 255));
                @(negedge clk);
                din = b;
                din_valid = 1'b1;
                model_byte(b);
                @(negedge clk);
                din_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle("rnd");
        end
        check_stream("random");
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL rnd_ovf: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_baud();
        int n;
        localparam int B = 27_000_000 / 115_200;
        din_valid2 = 1'b0;
        din2 = 8'h00;
        resetn2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn2 = 1'b1;
        fall_q.delete();
        rise_q.delete();
        @(negedge clk);
        din2 = 8'h00;
        din_valid2 = 1'b1;
        @(negedge clk);
        din_valid2 = 1'b0;
        n = 0;
        while (busy2 !== 1'b0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (n >= 20000 || fall_q.size() < 6 || rise_q.size() < 5) begin
            $display("FAIL baud_edges: got %0d falls want 6",
                     fall_q.size());
        end else begin
            n_pass++;
            n_checks++;
            if (rise_q[0] - fall_q[0] !== 5 * B)
                $display("FAIL baud_low5: got %0d want %0d",
                         rise_q[0] - fall_q[0], 5 * B);
            else n_pass++;
            n_checks++;
            if (fall_q[1] - rise_q[0] !== 2 * B)
                $display("FAIL baud_hi2: got %0d want %0d",
                         fall_q[1] - rise_q[0], 2 * B);
            else n_pass++;
            n_checks++;
            if (rise_q[1] - fall_q[1] !== 2 * B)
                $display("FAIL baud_lo2: got %0d want %0d",
                         rise_q[1] - fall_q[1], 2 * B);
            else n_pass++;
            n_checks++;
            if (rise_q[4] - fall_q[4] !== 6 * B)
                $display("FAIL baud_sp_lo: got %0d want %0d",
                         rise_q[4] - fall_q[4], 6 * B);
            else n_pass++;
            n_checks++;
            if (fall_q[5] - rise_q[4] !== B)
                $display("FAIL baud_bit: got %0d want %0d",
                         fall_q[5] - rise_q[4], B);
            else n_pass++;
            n_checks++;
            if (bfall - fall_q[4] !== 10 * B)
                $display("FAIL baud_frame: got %0d want %0d",
                         bfall - fall_q[4], 10 * B);
            else n_pass++;
        end
    endtask

    initial begin
        resetn2 = 1'b0;
        din2 = 8'h00;
        din_valid2 = 1'b0;
        test_reset();
        test_single();
        test_line();
        test_overflow();
        test_pop_collide();
        test_reset_midframe();
        test_random();
        test_baud();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
